// File: rtl/latch_phase_gen.sv
// Two-phase non-overlapping enable generator for master/slave D-latch banks.
// Free-run, single-step and graceful stop; every output is a register.
module latch_phase_gen #(
  parameter int PHASE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        RUN,
  input  logic        STEP,
  output logic        PH1,
  output logic        nPH1,
  output logic        PH2,
  output logic        nPH2,
  output logic        BUSY,
  output logic        CYCLE_DONE,
  output logic [15:0] CYCLE_CNT
);

  if (PHASE_CYCLES < 1 || PHASE_CYCLES > 15) begin : g_bad_phase
    $error("latch_phase_gen: PHASE_CYCLES must be 1..15");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 7) begin : g_bad_gap
    $error("latch_phase_gen: GAP_CYCLES must be 0..7");
  end

  localparam logic [3:0] PH_LD  = 4'(PHASE_CYCLES - 1);
  localparam logic [3:0] GAP_LD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  localparam bit         HAS_GAP = (GAP_CYCLES != 0);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    GAP1 = 3'd2,
    P2   = 3'd3,
    GAP2 = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        w_end;
  logic        r_ph1, r_nph1, r_ph2, r_nph2, r_busy, r_done;
  logic [15:0] r_cycle_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt - 4'd1;
    w_end       = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = r_cnt;
        if (RUN || STEP) begin
          w_state_nxt = P1;
          w_cnt_nxt   = PH_LD;
        end
      end
      P1: if (r_cnt == 4'd0) begin
        w_state_nxt = HAS_GAP ? GAP1 : P2;
        w_cnt_nxt   = HAS_GAP ? GAP_LD : PH_LD;
      end
      GAP1: if (r_cnt == 4'd0) begin
        w_state_nxt = P2;
        w_cnt_nxt   = PH_LD;
      end
      P2: if (r_cnt == 4'd0) begin
        if (HAS_GAP) begin
          w_state_nxt = GAP2;
          w_cnt_nxt   = GAP_LD;
        end else begin
          w_end = 1'b1;
        end
      end
      GAP2: if (r_cnt == 4'd0) w_end = 1'b1;
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
    // End of cycle: RUN sampled here decides between another cycle and IDLE.
    if (w_end) begin
      w_state_nxt = RUN ? P1 : IDLE;
      w_cnt_nxt   = RUN ? PH_LD : 4'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_ph1       <= 1'b0;
      r_nph1      <= 1'b1;
      r_ph2       <= 1'b0;
      r_nph2      <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cycle_cnt <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      // Outputs decode the next state so they align with the state register.
      r_ph1   <= (w_state_nxt == P1);
      r_nph1  <= (w_state_nxt != P1);
      r_ph2   <= (w_state_nxt == P2);
      r_nph2  <= (w_state_nxt != P2);
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_end;
      if (w_end) r_cycle_cnt <= r_cycle_cnt + 16'd1;
    end
  end

  assign PH1        = r_ph1;
  assign nPH1       = r_nph1;
  assign PH2        = r_ph2;
  assign nPH2       = r_nph2;
  assign BUSY       = r_busy;
  assign CYCLE_DONE = r_done;
  assign CYCLE_CNT  = r_cycle_cnt;

endmodule

// File: tb/tb_latch_phase_gen.sv
// Directed bench for latch_phase_gen: default instance plus a zero-gap,
// single-cycle-phase instance sharing clock and reset.
module tb_latch_phase_gen;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        RUN = 1'b0, STEP = 1'b0;
  logic        PH1, nPH1, PH2, nPH2, BUSY, CYCLE_DONE;
  logic [15:0] CYCLE_CNT;
  logic        RUN2 = 1'b0, STEP2 = 1'b0;
  logic        PH1_2, nPH1_2, PH2_2, nPH2_2, BUSY2, DONE2;
  logic [15:0] CNT2;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  latch_phase_gen dut (
    .CLK(CLK), .nRST(nRST), .RUN(RUN), .STEP(STEP),
    .PH1(PH1), .nPH1(nPH1), .PH2(PH2), .nPH2(nPH2),
    .BUSY(BUSY), .CYCLE_DONE(CYCLE_DONE), .CYCLE_CNT(CYCLE_CNT)
  );

  latch_phase_gen #(.PHASE_CYCLES(1), .GAP_CYCLES(0)) dut2 (
    .CLK(CLK), .nRST(nRST), .RUN(RUN2), .STEP(STEP2),
    .PH1(PH1_2), .nPH1(nPH1_2), .PH2(PH2_2), .nPH2(nPH2_2),
    .BUSY(BUSY2), .CYCLE_DONE(DONE2), .CYCLE_CNT(CNT2)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0; RUN = 1'b0; STEP = 1'b0; RUN2 = 1'b0; STEP2 = 1'b0;
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    tick(); tick();
    checks++;
    if ({PH1, nPH1, PH2, nPH2, BUSY, CYCLE_DONE} !== 6'b010100 || CYCLE_CNT !== 16'd0) begin
      failures++;
      $display("FAIL reset: ph1/nph1/ph2/nph2/busy/done=%b cnt=%h, want 010100 cnt=0000",
               {PH1, nPH1, PH2, nPH2, BUSY, CYCLE_DONE}, CYCLE_CNT);
    end
    nRST = 1'b1;
  endtask

  task automatic test_free_run();
    logic [6:0] e_ph1 = 7'b1000011; // bit k = expected after edge k
    logic [6:0] e_ph2 = 7'b0011000;
    int n;
    do_reset();
    RUN = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++;
      if (PH1 !== e_ph1[k] || PH2 !== e_ph2[k] || nPH1 !== ~PH1 || nPH2 !== ~PH2) begin
        failures++;
        $display("FAIL free_run phase e%0d: ph1=%b nph1=%b ph2=%b nph2=%b, want ph1=%b ph2=%b",
                 k, PH1, nPH1, PH2, nPH2, e_ph1[k], e_ph2[k]);
      end
      checks++;
      if (CYCLE_DONE !== (k == 6) || CYCLE_CNT !== ((k == 6) ? 16'd1 : 16'd0)) begin
        failures++;
        $display("FAIL free_run done e%0d: done=%b cnt=%0d, want done=%b cnt=%0d",
                 k, CYCLE_DONE, CYCLE_CNT, (k == 6), (k == 6) ? 1 : 0);
      end
    end
    RUN = 1'b0;
    n = 0;
    while (BUSY === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (BUSY !== 1'b0 || CYCLE_CNT !== 16'd2) begin
      failures++;
      $display("FAIL free_run stop: busy=%b cnt=%0d, want busy=0 cnt=2", BUSY, CYCLE_CNT);
    end
  endtask

  // Shared shape for a lone cycle started at edge 0, ending in IDLE after edge 6.
  localparam logic [7:0] ONE_PH1  = 8'b00000011;
  localparam logic [7:0] ONE_PH2  = 8'b00011000;
  localparam logic [7:0] ONE_BUSY = 8'b00111111;
  localparam logic [7:0] ONE_DONE = 8'b01000000;

  task automatic test_single_step();
    logic [7:0] e_ph1 = ONE_PH1, e_ph2 = ONE_PH2, e_busy = ONE_BUSY, e_done = ONE_DONE;
    do_reset();
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      checks++;
      if (PH1 !== e_ph1[k] || PH2 !== e_ph2[k] || BUSY !== e_busy[k] || CYCLE_DONE !== e_done[k]) begin
        failures++;
        $display("FAIL single_step e%0d: ph1=%b ph2=%b busy=%b done=%b, want %b %b %b %b",
                 k, PH1, PH2, BUSY, CYCLE_DONE, e_ph1[k], e_ph2[k], e_busy[k], e_done[k]);
      end
      STEP = (k == 1); // second STEP lands while BUSY and must be ignored
    end
    checks++;
    if (CYCLE_CNT !== 16'd1) begin
      failures++;
      $display("FAIL single_step count: cnt=%0d, want 1", CYCLE_CNT);
    end
  endtask

  task automatic test_graceful_stop();
    logic [7:0] e_ph1 = ONE_PH1, e_ph2 = ONE_PH2, e_busy = ONE_BUSY;
    int dones = 0;
    do_reset();
    RUN = 1'b1;
    tick();
    RUN = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      if (CYCLE_DONE === 1'b1) dones++;
      checks++;
      if (PH1 !== e_ph1[k] || PH2 !== e_ph2[k] || BUSY !== e_busy[k]) begin
        failures++;
        $display("FAIL graceful_stop e%0d: ph1=%b ph2=%b busy=%b, want %b %b %b",
                 k, PH1, PH2, BUSY, e_ph1[k], e_ph2[k], e_busy[k]);
      end
    end
    checks++;
    if (dones != 1 || CYCLE_CNT !== 16'd1) begin
      failures++;
      $display("FAIL graceful_stop done: pulses=%0d cnt=%0d, want pulses=1 cnt=1", dones, CYCLE_CNT);
    end
  endtask

  task automatic test_reset_mid_phase();
    do_reset();
    RUN = 1'b1;
    for (int k = 0; k < 10; k++) tick(); // after edge 9: PH2 of the second cycle
    checks++;
    if (PH2 !== 1'b1 || CYCLE_CNT !== 16'd1) begin
      failures++;
      $display("FAIL reset_mid setup: ph2=%b cnt=%0d, want ph2=1 cnt=1", PH2, CYCLE_CNT);
    end
    nRST = 1'b0;
    tick();
    checks++;
    if (PH2 !== 1'b0 || nPH2 !== 1'b1 || PH1 !== 1'b0 || CYCLE_CNT !== 16'd0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid abort: ph2=%b nph2=%b ph1=%b cnt=%0d busy=%b, want 0 1 0 0 0",
               PH2, nPH2, PH1, CYCLE_CNT, BUSY);
    end
    nRST = 1'b1;
    tick();
    checks++;
    if (PH1 !== 1'b1 || nPH1 !== 1'b0 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid restart: ph1=%b nph1=%b busy=%b, want 1 0 1", PH1, nPH1, BUSY);
    end
    RUN = 1'b0;
  endtask

  task automatic test_zero_gap();
    do_reset();
    RUN2 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (PH1_2 !== (k % 2 == 0) || PH2_2 !== (k % 2 == 1) || (PH1_2 & PH2_2) !== 1'b0 ||
          nPH1_2 !== ~PH1_2 || nPH2_2 !== ~PH2_2) begin
        failures++;
        $display("FAIL zero_gap phase e%0d: ph1=%b ph2=%b nph1=%b nph2=%b, want ph1=%b ph2=%b",
                 k, PH1_2, PH2_2, nPH1_2, nPH2_2, (k % 2 == 0), (k % 2 == 1));
      end
      checks++;
      if (DONE2 !== (k >= 2 && k % 2 == 0) || CNT2 !== 16'(k / 2)) begin
        failures++;
        $display("FAIL zero_gap done e%0d: done=%b cnt=%0d, want done=%b cnt=%0d",
                 k, DONE2, CNT2, (k >= 2 && k % 2 == 0), k / 2);
      end
    end
    RUN2 = 1'b0;
    tick();
    checks++;
    if (BUSY2 !== 1'b0 || CNT2 !== 16'd4) begin
      failures++;
      $display("FAIL zero_gap stop: busy=%b cnt=%0d, want busy=0 cnt=4", BUSY2, CNT2);
    end
  endtask

  task automatic test_wrap();
    force dut2.r_cycle_cnt = 16'hFFFF;
    tick();
    release dut2.r_cycle_cnt;
    checks++;
    if (CNT2 !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap preload: cnt=%h, want ffff", CNT2);
    end
    STEP2 = 1'b1;
    tick();
    STEP2 = 1'b0;
    tick(); tick(); // P1, P2, then end of cycle
    checks++;
    if (CNT2 !== 16'h0000 || DONE2 !== 1'b1 || BUSY2 !== 1'b0) begin
      failures++;
      $display("FAIL wrap: cnt=%h done=%b busy=%b, want 0000 1 0", CNT2, DONE2, BUSY2);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_single_step();
    test_graceful_stop();
    test_reset_mid_phase();
    test_zero_gap();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/latch_phase_gen.md
Name: latch_phase_gen

Overview:
- Generates the complementary, non-overlapping two-phase enable pairs (PH1/nPH1, PH2/nPH2) that drive the CLK/nCLK enable inputs of the master and slave D-latch banks.
- Sits directly upstream of every latch-based register in the core: PH1 opens master latches and PH2 opens slave latches.
- Supports free-run, single-step and graceful stop without ever truncating an open phase.

Parameters:
- PHASE_CYCLES, 2, CLK cycles each phase is held open; legal range 1..15.
- GAP_CYCLES, 1, dead CLK cycles after each phase with both phases closed; legal range 0..7. 0 removes the gap states.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- nRST  input  1  reset, synchronous and active-low.
- RUN  input  1  level; free-run request.
- STEP  input  1  single-cycle request; sampled only in IDLE.
- PH1  output  1  master-latch enable.
- nPH1  output  1  complement of PH1.
- PH2  output  1  slave-latch enable.
- nPH2  output  1  complement of PH2.
- BUSY  output  1  high whenever the state is not IDLE.
- CYCLE_DONE  output  1  one-CLK pulse per completed two-phase cycle.
- CYCLE_CNT  output  16  count of completed cycles, wraps.

Behaviour:
- Reset: on a CLK edge with nRST=0:
  - state=IDLE, PH1=PH2=0, nPH1=nPH2=1, BUSY=0, CYCLE_DONE=0, CYCLE_CNT=0.
  - Applies mid-phase too; the current phase is abandoned immediately.
- All outputs are registered and updated on the same edge as the state. No output is decoded combinationally.
- nPHx is a separate register loaded with the inverse of PHx on every edge, so nPHx == ~PHx in every cycle, including during reset.
- States: IDLE, P1, GAP1, P2, GAP2. A down-counter `cnt` (4 bits) tracks time in the current state.
- IDLE:
  - If RUN=1 or STEP=1 at an edge, go to P1 with cnt=PHASE_CYCLES-1.
  - PH1 is high in the cycle immediately following that edge (latency 1 edge).
- P1: PH1=1.
  - When cnt==0, go to GAP1 (cnt=GAP_CYCLES-1), or directly to P2 if GAP_CYCLES=0.
  - Otherwise decrement cnt.
- GAP1: PH1=PH2=0. When cnt==0, go to P2 (cnt=PHASE_CYCLES-1).
- P2: PH2=1.
  - When cnt==0, go to GAP2, or treat as end-of-cycle if GAP_CYCLES=0.
- End of cycle (last cycle of GAP2, or of P2 when GAP_CYCLES=0):
  - CYCLE_CNT increments by 1, wrapping 0xFFFF→0x0000.
  - CYCLE_DONE=1 for exactly the following cycle.
  - Next state is P1 if RUN=1 at that edge, else IDLE.
- Invariant: PH1 and PH2 are never both 1. With GAP_CYCLES=0 they swap on the same edge.
- Period of one cycle in CLK cycles = 2*(PHASE_CYCLES+GAP_CYCLES).
- RUN deasserted mid-cycle: the current cycle completes through GAP2, then IDLE. A phase is never shortened.
- STEP:
  - Ignored outside IDLE; no queuing.
  - STEP=1 with RUN=0 in IDLE gives exactly one cycle, then IDLE.
  - STEP and RUN both high in IDLE behave as RUN.
- Illegal parameter values are rejected at elaboration.

Test Plan:
- Free-run, defaults. nRST released, RUN=1 sampled at edge e0:
  - PH1=1 after e0 and e1; gap after e2; PH2=1 after e3 and e4; gap after e5.
  - PH1=1 again after e6, with CYCLE_DONE=1 and CYCLE_CNT=1 in that cycle.
  - nPHx == ~PHx in every cycle.
- Single step. STEP pulse in IDLE, RUN=0:
  - Exactly one PH1 window (2 cycles) and one PH2 window (2 cycles).
  - Then IDLE, BUSY=0, CYCLE_CNT=1.
  - A second STEP issued while BUSY has no effect.
- Graceful stop. RUN dropped during the first PH1 cycle:
  - PH1 still lasts 2 cycles and PH2 still lasts 2 cycles.
  - Ends in IDLE after 6 cycles with CYCLE_DONE pulsed once.
- Reset mid-phase. nRST=0 during PH2:
  - On the next edge PH2=0, nPH2=1, CYCLE_CNT=0, BUSY=0.
  - With RUN=1 after nRST returns high, PH1 restarts after one edge.
- Zero gap. GAP_CYCLES=0, PHASE_CYCLES=1, RUN=1:
  - PH1 and PH2 alternate every cycle with a period of 2.
  - They are never both high, and CYCLE_DONE pulses every 2 cycles.
- Wrap. Force CYCLE_CNT to 0xFFFF and complete one cycle:
  - CYCLE_CNT=0x0000 and CYCLE_DONE=1.
